// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: round constants, initial hash values, FSM
// state encoding and the bitwise helper functions used by the core.
package sha2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    ACCUM,
    OUT
  } state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // H0 lives in the top 32 bits, matching the digest port layout.
  localparam logic [255:0] IV_256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV_224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] S0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] S1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; the eight working words are
// packed a..h from MSB to LSB.
module sha256_round
  import sha2_pkg::*;
(
  input  logic [255:0] st_in,
  input  logic [31:0]  w,
  input  logic [31:0]  k,
  output logic [255:0] st_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = st_in;
  assign t1     = h + S1(e) + ch(e, f, g) + k + w;
  assign t2     = S0(a) + maj(a, b, c);
  assign st_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256/224 core: accepts pre-padded 512-bit blocks, runs UNROLL
// rounds per clock, chains blocks and presents the digest with backpressure.
module sha256_stream_core
  import sha2_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter bit EN_224 = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  input  logic         mode_224,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest,
  output logic         busy
);

  localparam logic [5:0] LAST_T = 6'(64 - UNROLL);

  state_t       state;
  logic [255:0] h_reg;
  logic [255:0] work;
  logic [31:0]  win    [16];
  logic [31:0]  w_next [16];
  logic [5:0]   t_idx;
  logic         chain_open;
  logic         mode_reg;
  logic         last_reg;
  logic [255:0] iv_first;
  logic [255:0] iv_mode;

  assign iv_first = (EN_224 && mode_224) ? IV_224 : IV_256;
  assign iv_mode  = mode_reg ? IV_224 : IV_256;

  // New schedule words; words beyond the first two depend on words made this cycle.
  for (genvar j = 0; j < UNROLL; j++) begin : g_sched
    logic [31:0] w_m2;
    logic [31:0] w_new;
    if (j < 2) begin : g_win
      assign w_m2 = win[14 + j];
    end else begin : g_chain
      assign w_m2 = g_sched[j - 2].w_new;
    end
    assign w_new = s1(w_m2) + win[9 + j] + s0(win[1 + j]) + win[j];
  end

  for (genvar i = 0; i < 16; i++) begin : g_shift
    if (i < 16 - UNROLL) begin : g_old
      assign w_next[i] = win[i + UNROLL];
    end else begin : g_new
      assign w_next[i] = g_sched[i - 16 + UNROLL].w_new;
    end
  end

  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    logic [255:0] st_in;
    logic [255:0] st_out;
    if (j == 0) begin : g_head
      assign st_in = work;
    end else begin : g_tail
      assign st_in = g_rnd[j - 1].st_out;
    end
    sha256_round u_round (
      .st_in  (st_in),
      .w      (win[j]),
      .k      (K[t_idx + 6'(j)]),
      .st_out (st_out)
    );
  end

  assign blk_ready = (state == IDLE);
  assign dig_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign digest    = mode_reg ? {h_reg[255:32], 32'h0} : h_reg;

  // NOTE: every register here, the schedule window included, is cleared by the
  // async reset so a reset mid-block can never leak a partial hash.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      h_reg      <= '0;
      work       <= '0;
      t_idx      <= '0;
      chain_open <= 1'b0;
      mode_reg   <= 1'b0;
      last_reg   <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every read in this block on the
      // pre-edge value, so ordering of the statements does not matter.
      case (state)
        IDLE: begin
          if (blk_valid) begin
            for (int i = 0; i < 16; i++) win[i] <= blk_data[511 - 32*i -: 32];
            last_reg <= blk_last;
            t_idx    <= '0;
            state    <= ROUND;
            if (blk_first) begin
              mode_reg <= EN_224 && mode_224;
              h_reg    <= iv_first;
              work     <= iv_first;
            end else if (chain_open) begin
              work <= h_reg;
            end else begin
              h_reg <= iv_mode;
              work  <= iv_mode;
            end
          end
        end
        ROUND: begin
          work  <= g_rnd[UNROLL - 1].st_out;
          win   <= w_next;
          t_idx <= t_idx + 6'(UNROLL);
          if (t_idx == LAST_T) state <= ACCUM;
        end
        ACCUM: begin
          for (int i = 0; i < 8; i++)
            h_reg[32*i +: 32] <= h_reg[32*i +: 32] + work[32*i +: 32];
          chain_open <= !last_reg;
          state      <= last_reg ? OUT : IDLE;
        end
        OUT: begin
          if (dig_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench: drives UNROLL=1,2,4 cores in lockstep with known SHA-256/224
// vectors and checks digests, latency, backpressure and reset abort.
module tb_sha256_stream_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         mode_224;
  logic         dig_ready;
  logic         blk_ready_v [3];
  logic         dig_valid_v [3];
  logic         busy_v      [3];
  logic [255:0] digest_v    [3];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar u = 0; u < 3; u++) begin : g_dut
    sha256_stream_core #(.UNROLL(1 << u), .EN_224(1'b1)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready_v[u]),
      .blk_data  (blk_data),
      .blk_first (blk_first),
      .blk_last  (blk_last),
      .mode_224  (mode_224),
      .dig_valid (dig_valid_v[u]),
      .dig_ready (dig_ready),
      .digest    (digest_v[u]),
      .busy      (busy_v[u])
    );
  end

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO_1 =
    512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
  localparam logic [511:0] BLK_TWO_2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] DIG_ABC_224 =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transfer one block into all three cores at the same edge, then measure
  // cycles until each core is ready again or shows a digest.
  task automatic send_block(input logic [511:0] data, input logic first, input logic last,
                            input logic m224, input string tag);
    int lat  [3];
    bit seen [3];
    int wait_cyc = 0;
    while (!(blk_ready_v[0] && blk_ready_v[1] && blk_ready_v[2]) && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    check({tag, "_all_ready"}, 256'(blk_ready_v[0] && blk_ready_v[1] && blk_ready_v[2]), 256'd1);
    blk_valid = 1'b1;
    blk_data  = data;
    blk_first = first;
    blk_last  = last;
    mode_224  = m224;
    @(posedge clk);
    @(negedge clk);
    blk_valid = 1'b0;
    blk_data  = ~data;
    blk_first = ~first;
    blk_last  = ~last;
    mode_224  = ~m224;
    for (int u = 0; u < 3; u++) begin
      lat[u]  = 0;
      seen[u] = 1'b0;
    end
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 3; u++)
        if (!seen[u] && (dig_valid_v[u] || blk_ready_v[u])) begin
          seen[u] = 1'b1;
          lat[u]  = cyc;
        end
    end
    for (int u = 0; u < 3; u++)
      check($sformatf("%s_latency_u%0d", tag, 1 << u), 256'(lat[u]), 256'(64 / (1 << u) + 1));
  endtask

  task automatic take_digest(input logic [255:0] exp, input string tag);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("%s_dig_valid_u%0d", tag, 1 << u), 256'(dig_valid_v[u]), 256'd1);
      check($sformatf("%s_digest_u%0d", tag, 1 << u), digest_v[u], exp);
    end
    dig_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dig_ready = 1'b0;
    for (int u = 0; u < 3; u++)
      check($sformatf("%s_ready_after_u%0d", tag, 1 << u), 256'(blk_ready_v[u]), 256'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    blk_first = 1'b0;
    blk_last  = 1'b0;
    mode_224  = 1'b0;
    dig_ready = 1'b0;
    #12;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst_blk_ready_u%0d", 1 << u), 256'(blk_ready_v[u]), 256'd1);
      check($sformatf("rst_dig_valid_u%0d", 1 << u), 256'(dig_valid_v[u]), 256'd0);
      check($sformatf("rst_busy_u%0d", 1 << u), 256'(busy_v[u]), 256'd0);
      check($sformatf("rst_digest_u%0d", 1 << u), digest_v[u], 256'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single-block "abc", first and last together.
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0, "abc");
    take_digest(DIG_ABC, "abc");

    // No open chain after OUT: a non-first block restarts from the SHA-256 IV.
    send_block(BLK_ABC, 1'b0, 1'b1, 1'b0, "abc_nofirst");
    take_digest(DIG_ABC, "abc_nofirst");

    // Two-block message with chaining.
    send_block(BLK_TWO_1, 1'b1, 1'b0, 1'b0, "two_b1");
    for (int u = 0; u < 3; u++)
      check($sformatf("two_b1_no_digest_u%0d", 1 << u), 256'(dig_valid_v[u]), 256'd0);
    send_block(BLK_TWO_2, 1'b0, 1'b1, 1'b0, "two_b2");
    take_digest(DIG_TWO, "two");

    // SHA-224 "abc", then a non-first block reuses the latched SHA-224 mode.
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b1, "abc224");
    take_digest(DIG_ABC_224, "abc224");
    send_block(BLK_ABC, 1'b0, 1'b1, 1'b0, "abc224_latched");
    take_digest(DIG_ABC_224, "abc224_latched");

    // Empty message held under backpressure.
    send_block(BLK_EMPTY, 1'b1, 1'b1, 1'b0, "empty");
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        check($sformatf("hold_digest_c%0d_u%0d", cyc, 1 << u), digest_v[u], DIG_EMPTY);
        check($sformatf("hold_blk_ready_c%0d_u%0d", cyc, 1 << u), 256'(blk_ready_v[u]), 256'd0);
      end
    end
    take_digest(DIG_EMPTY, "empty");

    // A new first block discards an open chain.
    send_block(BLK_TWO_1, 1'b1, 1'b0, 1'b0, "discard_b1");
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0, "discard_abc");
    take_digest(DIG_ABC, "discard_abc");

    // Reset at round 10 of block 1, then resend "abc".
    blk_valid = 1'b1;
    blk_data  = BLK_TWO_1;
    blk_first = 1'b1;
    blk_last  = 1'b0;
    mode_224  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    blk_valid = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("abort_dig_valid_u%0d", 1 << u), 256'(dig_valid_v[u]), 256'd0);
      check($sformatf("abort_blk_ready_u%0d", 1 << u), 256'(blk_ready_v[u]), 256'd1);
      check($sformatf("abort_busy_u%0d", 1 << u), 256'(busy_v[u]), 256'd0);
      check($sformatf("abort_digest_u%0d", 1 << u), digest_v[u], 256'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      for (int u = 0; u < 3; u++)
        check($sformatf("abort_idle_c%0d_u%0d", cyc, 1 << u), 256'(dig_valid_v[u]), 256'd0);
    end
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b0, "resend_abc");
    take_digest(DIG_ABC, "resend_abc");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_stream_core.md
SHA256_STREAM_CORE -- requirements
Module: sha256_stream_core

Interface
REQ-001 SHALL have parameter UNROLL, default 1, meaning rounds per clock; legal values 1, 2, 4.
REQ-002 SHALL have parameter EN_224, default 1, meaning SHA-224 mode support; when 0, mode_224 is ignored.
REQ-003 SHALL have port clk, input, 1 bit: the clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port blk_valid, input, 1 bit: a message block is offered.
REQ-006 SHALL have port blk_ready, output, 1 bit: the core accepts a block.
REQ-007 SHALL have port blk_data, input, 512 bits: pre-padded block, W0 in bits [511:480].
REQ-008 SHALL have port blk_first, input, 1 bit: the block starts a new message.
REQ-009 SHALL have port blk_last, input, 1 bit: the block ends the message.
REQ-010 SHALL have port mode_224, input, 1 bit: selects SHA-224; sampled only with blk_first.
REQ-011 SHALL have port dig_valid, output, 1 bit: the digest is available.
REQ-012 SHALL have port dig_ready, input, 1 bit: the consumer accepts the digest.
REQ-013 SHALL have port digest, output, 256 bits: H0 in bits [255:224]; in SHA-224 mode, bits [31:0] are 0.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, ROUND, ACCUM and OUT.
- IDLE to ROUND on a block transfer (blk_valid && blk_ready).
- ROUND to ACCUM after R = 64/UNROLL cycles.
- ACCUM to OUT if the block was last; otherwise ACCUM to IDLE.
- OUT to IDLE on dig_valid && dig_ready.
REQ-016 blk_ready SHALL equal (state==IDLE); dig_valid SHALL equal (state==OUT).
REQ-017 On a transfer with blk_first=1, the working registers SHALL load the SHA-256 IV, or the SHA-224 IV when mode_224 && EN_224; the mode SHALL be latched for the whole message.
REQ-018 On a transfer with blk_first=0, the working registers SHALL load the chained H0..H7.
- Exception: if no chain is open (after reset or after OUT), the IV of the latched mode SHALL be used.
REQ-019 The message schedule SHALL be a 16-word sliding window.
- New words are Wt = s1(Wt-2) + Wt-7 + s0(Wt-15) + Wt-16, mod 2^32.
- Exactly UNROLL words are consumed per ROUND cycle.
REQ-020 All additions SHALL be modulo 2^32; no carries are kept.
REQ-021 ACCUM SHALL perform Hi <= Hi + working_i for i = 0..7, in one cycle.
REQ-022 Timing: transfer at edge T; rounds at edges T+1..T+R; accumulate at edge T+R+1; dig_valid or blk_ready high after edge T+R+1.
REQ-023 digest SHALL stay stable while dig_valid=1 && dig_ready=0 (indefinite backpressure).
REQ-024 blk_first=1 with blk_last=1 SHALL be treated as a single-block message.
REQ-025 blk_first=1 while a chain is open SHALL discard the chain and restart from the IV.
REQ-026 Inputs other than blk_valid SHALL be ignored when no transfer occurs; blk_data SHALL be captured only at the transfer edge.

Reset
REQ-027 On reset low, asynchronously:
- state SHALL be IDLE, with the chain closed and the mode set to SHA-256.
- blk_ready SHALL be 1; dig_valid and busy SHALL be 0; digest SHALL be 0.
- H, the working registers, the schedule window and the round counter SHALL be 0.
REQ-028 Reset mid-ROUND or mid-OUT SHALL abort the operation without emitting a digest; the first block after reset SHALL use the IV.

Structure
REQ-029 Shared package sha2_pkg SHALL hold:
- the K[0:63] table;
- the SHA-256 and SHA-224 IVs;
- the state enum;
- the functions rotr, ch, maj, S0, S1, s0 and s1.
REQ-030 One sub-module, sha256_round, SHALL implement one combinational compression round; it SHALL be instantiated UNROLL times in a chain.

Verification
REQ-031 Single block "abc" (616263 80.. len 0x18), first=last=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; dig_valid at T+R+1.
REQ-032 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-033 "abc" with mode_224=1 -> digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
REQ-034 Empty message with dig_ready held 0 for 20 cycles:
- digest stays e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855;
- blk_ready stays 0 until the digest is accepted.
REQ-035 Reset asserted at round 10 of block 1 of the two-block message, then "abc" re-sent -> no dig_valid before the resend; the resend gives the REQ-031 digest.
REQ-036 Regressions for UNROLL=1, 2 and 4 SHALL give identical digests, with latency R+1 = 65, 33 and 17 respectively.
